// File: rtl/usb_packet_decoder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_pkg : shared PID, CRC and state definitions for the USB packet decoder
// Rev 1.0
// ---------------------------------------------------------------------------
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_DATA2 = 4'h7;
    localparam logic [3:0] PID_MDATA = 4'hF;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_NYET  = 4'h6;

    localparam logic [4:0]  CRC5_INIT      = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;

    typedef enum logic [1:0] {
        CLS_SPECIAL   = 2'b00,
        CLS_TOKEN     = 2'b01,
        CLS_HANDSHAKE = 2'b10,
        CLS_DATA      = 2'b11
    } pid_class_e;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_PID   = 3'd1,
        ERR_CRC   = 3'd2,
        ERR_LEN   = 3'd3,
        ERR_UNSUP = 3'd4
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TOK1    = 3'd1,
        ST_TOK2    = 3'd2,
        ST_TOK_END = 3'd3,
        ST_DATA    = 3'd4,
        ST_HS_END  = 3'd5,
        ST_DRAIN   = 3'd6
    } dec_state_e;

    function automatic logic pid_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

    function automatic pid_class_e pid_class(input logic [1:0] p);
        return pid_class_e'(p);
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_packet_decoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_packet_decoder_if : byte-stream input and decoded-packet output bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface usb_packet_decoder_if #(
    parameter int CNT_W = 11
);
    logic             new_byte;
    logic [7:0]       rx_data;
    logic             rx_end;
    logic [3:0]       pid;
    logic             pid_valid;
    logic [6:0]       token_addr;
    logic [3:0]       token_endp;
    logic             token_valid;
    logic [7:0]       data_byte;
    logic             data_valid;
    logic             pkt_done;
    logic             pkt_error;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] byte_count;

    modport master (
        output new_byte, rx_data, rx_end,
        input  pid, pid_valid, token_addr, token_endp, token_valid,
               data_byte, data_valid, pkt_done, pkt_error, err_code, byte_count
    );

    modport slave (
        input  new_byte, rx_data, rx_end,
        output pid, pid_valid, token_addr, token_endp, token_valid,
               data_byte, data_valid, pkt_done, pkt_error, err_code, byte_count
    );
endinterface
`default_nettype wire

// File: rtl/usb_packet_decoder_crc_update.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_crc_update : one-byte unrolled CRC5/CRC16 update, LSB of byte first
// Rev 1.0
// ---------------------------------------------------------------------------
module usb_crc_update
    import usb_pkg::*;
(
    input  logic [7:0]  data,
    input  logic [4:0]  crc5_in,
    input  logic [15:0] crc16_in,
    output logic [4:0]  crc5_out,
    output logic [15:0] crc16_out
);

    logic [4:0]  c5;
    logic [15:0] c16;

    always_comb begin
        c5  = crc5_in;
        c16 = crc16_in;
        for (int i = 0; i < 8; i++) begin
            c5  = {c5[3:0], 1'b0}   ^ ({5{data[i] ^ c5[4]}}   & CRC5_POLY);
            c16 = {c16[14:0], 1'b0} ^ ({16{data[i] ^ c16[15]}} & CRC16_POLY);
        end
        crc5_out  = c5;
        crc16_out = c16;
    end

endmodule
`default_nettype wire

// File: rtl/usb_packet_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_packet_decoder : PID check, packet classification, CRC5/CRC16 check,
//                      payload forwarding with CRC bytes stripped
// Rev 1.0
// ---------------------------------------------------------------------------
module usb_packet_decoder
    import usb_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1023,
    parameter int CNT_W       = 11
) (
    input  logic                 clk,
    input  logic                 n_rst,
    usb_packet_decoder_if.slave  bus
);

    dec_state_e       state;
    logic [4:0]       crc5;
    logic [15:0]      crc16;
    logic [7:0]       tok_lo;
    logic [7:0]       buf0;
    logic [7:0]       buf1;
    logic [1:0]       buf_cnt;
    err_code_e        drain_err;
    logic [CNT_W-1:0] count;

    logic [4:0]       crc5_upd;
    logic [15:0]      crc16_upd;

    // State after the current byte is applied; rx_end is judged against these
    dec_state_e       st_b;
    logic [4:0]       crc5_b;
    logic [15:0]      crc16_b;
    logic [1:0]       buf_cnt_b;
    err_code_e        err_b;
    err_code_e        end_err;
    logic [CNT_W-1:0] count_b;
    logic             emit_b;
    logic             pid_accept;

    usb_crc_update u_crc (
        .data      (bus.rx_data),
        .crc5_in   (crc5),
        .crc16_in  (crc16),
        .crc5_out  (crc5_upd),
        .crc16_out (crc16_upd)
    );

    always_comb begin
        st_b       = state;
        crc5_b     = crc5;
        crc16_b    = crc16;
        buf_cnt_b  = buf_cnt;
        err_b      = drain_err;
        count_b    = count;
        emit_b     = 1'b0;
        pid_accept = 1'b0;
        if (bus.new_byte) begin
            unique case (state)
                ST_IDLE: begin
                    crc5_b    = CRC5_INIT;
                    crc16_b   = CRC16_INIT;
                    buf_cnt_b = 2'd0;
                    count_b   = '0;
                    err_b     = ERR_NONE;
                    if (!pid_ok(bus.rx_data)) begin
                        st_b  = ST_DRAIN;
                        err_b = ERR_PID;
                    end else begin
                        pid_accept = 1'b1;
                        unique case (pid_class(bus.rx_data[1:0]))
                            CLS_TOKEN:     st_b = ST_TOK1;
                            CLS_DATA:      st_b = ST_DATA;
                            CLS_HANDSHAKE: st_b = ST_HS_END;
                            default: begin
                                pid_accept = 1'b0;
                                st_b       = ST_DRAIN;
                                err_b      = ERR_UNSUP;
                            end
                        endcase
                    end
                end
                ST_TOK1: begin
                    st_b   = ST_TOK2;
                    crc5_b = crc5_upd;
                end
                ST_TOK2: begin
                    st_b   = ST_TOK_END;
                    crc5_b = crc5_upd;
                end
                ST_TOK_END, ST_HS_END: begin
                    st_b  = ST_DRAIN;
                    err_b = ERR_LEN;
                end
                ST_DATA: begin
                    crc16_b = crc16_upd;
                    if (buf_cnt == 2'd2) begin
                        emit_b  = 1'b1;
                        count_b = count + CNT_W'(1);
                        if (count_b == CNT_W'(MAX_PAYLOAD + 1)) begin
                            st_b  = ST_DRAIN;
                            err_b = ERR_LEN;
                        end
                    end else begin
                        buf_cnt_b = buf_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end

        unique case (st_b)
            ST_TOK1, ST_TOK2: end_err = ERR_LEN;
            ST_TOK_END:       end_err = (crc5_b == CRC5_RESIDUAL) ? ERR_NONE : ERR_CRC;
            ST_DATA:          end_err = (buf_cnt_b != 2'd2) ? ERR_LEN :
                                        (crc16_b == CRC16_RESIDUAL) ? ERR_NONE : ERR_CRC;
            ST_DRAIN:         end_err = err_b;
            default:          end_err = ERR_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= ST_IDLE;
            crc5            <= CRC5_INIT;
            crc16           <= CRC16_INIT;
            tok_lo          <= '0;
            buf0            <= '0;
            buf1            <= '0;
            buf_cnt         <= '0;
            drain_err       <= ERR_NONE;
            count           <= '0;
            bus.pid         <= '0;
            bus.pid_valid   <= 1'b0;
            bus.token_addr  <= '0;
            bus.token_endp  <= '0;
            bus.token_valid <= 1'b0;
            bus.data_byte   <= '0;
            bus.data_valid  <= 1'b0;
            bus.pkt_done    <= 1'b0;
            bus.pkt_error   <= 1'b0;
            bus.err_code    <= '0;
            bus.byte_count  <= '0;
        end else begin
            state           <= st_b;
            crc5            <= crc5_b;
            crc16           <= crc16_b;
            buf_cnt         <= buf_cnt_b;
            drain_err       <= err_b;
            count           <= count_b;
            bus.pid_valid   <= pid_accept;
            bus.data_valid  <= emit_b;
            bus.token_valid <= 1'b0;
            bus.pkt_done    <= 1'b0;
            if (pid_accept)
                bus.pid <= bus.rx_data[3:0];
            if (bus.new_byte && state == ST_TOK1)
                tok_lo <= bus.rx_data;
            if (bus.new_byte && state == ST_TOK2) begin
                bus.token_addr <= tok_lo[6:0];
                bus.token_endp <= {bus.rx_data[2:0], tok_lo[7]};
            end
            if (bus.new_byte && state == ST_DATA) begin
                if (buf_cnt == 2'd0) begin
                    buf0 <= bus.rx_data;
                end else if (buf_cnt == 2'd1) begin
                    buf1 <= bus.rx_data;
                end else begin
                    buf0 <= buf1;
                    buf1 <= bus.rx_data;
                end
            end
            if (emit_b)
                bus.data_byte <= buf0;
            if (bus.rx_end && st_b != ST_IDLE) begin
                state           <= ST_IDLE;
                buf_cnt         <= '0;
                bus.pkt_done    <= 1'b1;
                bus.pkt_error   <= (end_err != ERR_NONE);
                bus.err_code    <= end_err;
                bus.byte_count  <= count_b;
                bus.token_valid <= (st_b == ST_TOK_END) && (end_err == ERR_NONE);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_packet_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_usb_packet_decoder : directed scoreboard bench for usb_packet_decoder
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_usb_packet_decoder;

    localparam int MAX_PAYLOAD = 1023;
    localparam int CNT_W       = 11;

    typedef struct packed {
        logic        tv;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic        err;
        logic [2:0]  code;
        logic [10:0] cnt;
    } done_t;

    logic clk;
    logic n_rst;

    usb_packet_decoder_if #(.CNT_W(CNT_W)) bus ();

    usb_packet_decoder #(.MAX_PAYLOAD(MAX_PAYLOAD), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] exp_data[$];
    logic [7:0] obs_data[$];
    logic [3:0] exp_pid[$];
    logic [3:0] obs_pid[$];
    done_t      exp_done[$];
    done_t      obs_done[$];
    logic [7:0] pl[$];

    int vectors     = 0;
    int miscompares = 0;

    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.data_valid) obs_data.push_back(bus.data_byte);
            if (bus.pid_valid)  obs_pid.push_back(bus.pid);
            if (bus.pkt_done)
                obs_done.push_back({bus.token_valid, bus.token_addr, bus.token_endp,
                                    bus.pkt_error, bus.err_code, bus.byte_count});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic nb, input logic [7:0] d, input logic e);
        bus.new_byte = nb;
        bus.rx_data  = d;
        bus.rx_end   = e;
        @(posedge clk); #1;
        bus.new_byte = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_end   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Reflected-form reference CRCs; both return the complemented value as sent
    function automatic logic [15:0] crc16_model();
        logic [15:0] c = 16'hFFFF;
        foreach (pl[i])
            for (int j = 0; j < 8; j++)
                c = (c[0] ^ pl[i][j]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return ~c;
    endfunction

    function automatic logic [4:0] crc5_model(input logic [10:0] f);
        logic [4:0] c = 5'h1F;
        for (int j = 0; j < 11; j++)
            c = (c[0] ^ f[j]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
        return ~c;
    endfunction

    function automatic done_t mk_done(input logic tv, input logic [6:0] a, input logic [3:0] e,
                                      input logic [2:0] code, input logic [10:0] cnt);
        return '{tv: tv, addr: a, endp: e, err: (code != 3'd0), code: code, cnt: cnt};
    endfunction

    task automatic check_packet();
        int    t = 0;
        done_t o;
        done_t e;
        while (obs_done.size() == 0 && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        chk("pkt_done_seen", 64'(obs_done.size() != 0), 64'd1);
        e = exp_done.pop_front();
        if (obs_done.size() != 0) begin
            o = obs_done.pop_front();
            chk("token_valid", 64'(o.tv),   64'(e.tv));
            chk("pkt_error",   64'(o.err),  64'(e.err));
            chk("err_code",    64'(o.code), 64'(e.code));
            chk("byte_count",  64'(o.cnt),  64'(e.cnt));
            if (e.tv) begin
                chk("token_addr", 64'(o.addr), 64'(e.addr));
                chk("token_endp", 64'(o.endp), 64'(e.endp));
            end
        end
        idle(2);
        chk("pid_valid_count", 64'(obs_pid.size()), 64'(exp_pid.size()));
        while (obs_pid.size() != 0 && exp_pid.size() != 0)
            chk("pid", 64'(obs_pid.pop_front()), 64'(exp_pid.pop_front()));
        chk("data_valid_count", 64'(obs_data.size()), 64'(exp_data.size()));
        while (obs_data.size() != 0 && exp_data.size() != 0)
            chk("data_byte", 64'(obs_data.pop_front()), 64'(exp_data.pop_front()));
        obs_pid.delete();  exp_pid.delete();
        obs_data.delete(); exp_data.delete();
        chk("extra_pkt_done", 64'(obs_done.size()), 64'd0);
        obs_done.delete();
    endtask

    task automatic send_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                              input logic [7:0] flip);
        logic [10:0] f;
        logic [7:0]  b2;
        f  = {e, a};
        b2 = {crc5_model(f), f[10:8]} ^ flip;
        exp_pid.push_back(p);
        exp_done.push_back((flip == 8'h00) ? mk_done(1'b1, a, e, 3'd0, 11'd0)
                                           : mk_done(1'b0, a, e, 3'd2, 11'd0));
        drive(1'b1, {~p, p}, 1'b0);
        drive(1'b1, f[7:0], 1'b0);
        drive(1'b1, b2, 1'b0);
        idle(1);
        drive(1'b0, 8'h00, 1'b1);
        check_packet();
    endtask

    // Sends pid + pl + CRC16; every byte but the last two CRC bytes should come out
    task automatic send_data(input logic [3:0] p, input int gap, input bit bad_crc,
                             input bit end_with_last);
        logic [7:0]  s[$];
        logic [15:0] c;
        int          n_emit;
        logic [2:0]  code;
        c = crc16_model();
        s = pl;
        s.push_back(c[7:0]);
        s.push_back(c[15:8]);
        if (bad_crc) s[s.size()-1] = s[s.size()-1] ^ 8'h01;
        n_emit = s.size() - 2;
        if (n_emit > MAX_PAYLOAD + 1) n_emit = MAX_PAYLOAD + 1;
        code = (n_emit > MAX_PAYLOAD) ? 3'd3 : (bad_crc ? 3'd2 : 3'd0);
        for (int i = 0; i < n_emit; i++) exp_data.push_back(s[i]);
        exp_pid.push_back(p);
        exp_done.push_back(mk_done(1'b0, 7'd0, 4'd0, code, 11'(n_emit)));
        drive(1'b1, {~p, p}, 1'b0);
        idle(gap);
        for (int i = 0; i < s.size(); i++) begin
            drive(1'b1, s[i], (end_with_last && i == s.size() - 1));
            idle(gap);
        end
        if (!end_with_last) drive(1'b0, 8'h00, 1'b1);
        check_packet();
    endtask

    function automatic logic [41:0] all_outs();
        return {bus.pid, bus.pid_valid, bus.token_addr, bus.token_endp, bus.token_valid,
                bus.data_byte, bus.data_valid, bus.pkt_done, bus.pkt_error, bus.err_code,
                bus.byte_count};
    endfunction

    initial begin
        bus.new_byte = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_end   = 1'b0;
        n_rst        = 1'b1;
        #2 n_rst = 1'b0;
        #3 chk("reset_outputs", 64'(all_outs()), 64'd0);
        idle(3);
        n_rst = 1'b1;
        idle(2);

        // ACK handshake
        exp_pid.push_back(4'h2);
        exp_done.push_back(mk_done(1'b0, 7'd0, 4'd0, 3'd0, 11'd0));
        drive(1'b1, 8'hD2, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check_packet();

        // Tokens: good IN, corrupted IN, good SOF with frame 0x7A5
        send_token(4'h9, 7'h15, 4'hE, 8'h00);
        send_token(4'h9, 7'h15, 4'hE, 8'h80);
        send_token(4'h5, 7'h25, 4'hF, 8'h00);

        // Zero-length DATA1
        pl.delete();
        send_data(4'hB, 0, 1'b0, 1'b0);

        // DATA0 00..03, one byte every 4 cycles, then with end on the last byte
        pl = '{8'h00, 8'h01, 8'h02, 8'h03};
        send_data(4'h3, 3, 1'b0, 1'b0);
        send_data(4'h3, 3, 1'b0, 1'b1);

        // Bad CRC16: forwarded payload stays forwarded
        pl = '{8'hA5, 8'h5A, 8'h3C};
        send_data(4'h3, 1, 1'b1, 1'b0);

        // PID complement failure and unsupported class
        exp_done.push_back(mk_done(1'b0, 7'd0, 4'd0, 3'd1, 11'd0));
        drive(1'b1, 8'hC4, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check_packet();
        exp_done.push_back(mk_done(1'b0, 7'd0, 4'd0, 3'd4, 11'd0));
        drive(1'b1, 8'hF0, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check_packet();

        // Truncated token, oversized handshake, one-byte data packet
        exp_pid.push_back(4'h1);
        exp_done.push_back(mk_done(1'b0, 7'd0, 4'd0, 3'd3, 11'd0));
        drive(1'b1, 8'hE1, 1'b0);
        drive(1'b1, 8'h15, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check_packet();
        exp_pid.push_back(4'h2);
        exp_done.push_back(mk_done(1'b0, 7'd0, 4'd0, 3'd3, 11'd0));
        drive(1'b1, 8'hD2, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check_packet();
        exp_pid.push_back(4'h3);
        exp_done.push_back(mk_done(1'b0, 7'd0, 4'd0, 3'd3, 11'd0));
        drive(1'b1, 8'hC3, 1'b0);
        drive(1'b1, 8'h55, 1'b1);
        check_packet();

        // Maximum payload accepted, one byte more is a length error
        pl.delete();
        for (int i = 0; i < MAX_PAYLOAD; i++) pl.push_back(8'(i * 7));
        send_data(4'h7, 0, 1'b0, 1'b0);
        pl.push_back(8'h99);
        send_data(4'h7, 0, 1'b0, 1'b0);

        // Reset mid-DATA: silent abort
        exp_pid.push_back(4'h3);
        drive(1'b1, 8'hC3, 1'b0);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        n_rst = 1'b0;
        #2 chk("midpkt_reset_outputs", 64'(all_outs()), 64'd0);
        idle(2);
        n_rst = 1'b1;
        idle(1);
        drive(1'b0, 8'h00, 1'b1);
        idle(5);
        chk("no_done_after_reset", 64'(obs_done.size()), 64'd0);
        chk("pid_before_reset_count", 64'(obs_pid.size()), 64'd1);
        if (obs_pid.size() != 0)
            chk("pid_before_reset", 64'(obs_pid.pop_front()), 64'(exp_pid.pop_front()));
        chk("no_data_after_reset", 64'(obs_data.size()), 64'd0);
        obs_pid.delete(); exp_pid.delete(); obs_done.delete(); obs_data.delete();

        // Clean packet after reset
        pl = '{8'hDE, 8'hAD};
        send_data(4'hB, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_packet_decoder.md
Name: usb_packet_decoder

Overview:
Consumes the byte stream the ULPI receive state machine produces (one new_byte pulse per received byte, plus a packet-end pulse when the PHY drops dir) and decodes it into USB packets. It performs these checks:
- validates the PID byte;
- classifies the packet as token, data or handshake;
- checks CRC5 (token) or CRC16 (data);
- forwards data-packet payload bytes with both CRC bytes stripped.

It sits between the ULPI receive FSM and the endpoint/protocol engine.

Parameters:
MAX_PAYLOAD, 1023, maximum data-packet payload bytes, excluding PID and CRC; exceeding it is a length error.
CNT_W, 11, width of the payload byte counter; must hold MAX_PAYLOAD+1.

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
new_byte  in  1  single-cycle strobe; rx_data valid this cycle
rx_data  in  8  received byte from the ULPI receive FSM
rx_end  in  1  single-cycle strobe; packet ended (dir fell)
pid  out  4  PID of the current/last packet; valid from pid_valid
pid_valid  out  1  1-cycle pulse when a PID byte passes the check
token_addr  out  7  token field[6:0]
token_endp  out  4  token field[10:7]; for SOF, {token_endp,token_addr} is the frame number
token_valid  out  1  1-cycle pulse; token fields valid, CRC5 good
data_byte  out  8  payload byte
data_valid  out  1  1-cycle pulse per payload byte
pkt_done  out  1  1-cycle pulse at packet completion (good or bad)
pkt_error  out  1  qualifies pkt_done; 1 = packet bad
err_code  out  3  0 none, 1 PID check, 2 CRC, 3 length, 4 unsupported PID; held until next pkt_done
byte_count  out  CNT_W  payload bytes forwarded; valid at pkt_done

Behaviour:
- Reset: all outputs 0; state IDLE; CRC registers at init; holding buffer empty.
- PID byte is accepted only if rx_data[7:4] == ~rx_data[3:0]. Otherwise go to DRAIN with err_code 1.
- PID class by pid[1:0]:
  - 01: token (OUT 1, IN 9, SOF 5, SETUP D)
  - 11: data (DATA0 3, DATA1 B, DATA2 7, MDATA F)
  - 10: handshake (ACK 2, NAK A, STALL E, NYET 6)
  - 00: unsupported, go to DRAIN with err_code 4.
- FSM states: IDLE, TOK1, TOK2, TOK_END, DATA, HS_END, DRAIN.
  - IDLE: new_byte checks the PID. On pass, pid_valid pulses the next cycle, then go to TOK1, DATA or HS_END. CRC5 is set to 5'h1F and CRC16 to 16'hFFFF.
  - TOK1 and TOK2: capture one byte each, LSB first, into the token field and the CRC5. field[10:0] = {byte2[2:0], byte1}.
  - TOK_END: the next rx_end checks the CRC5 residual against 5'b01100.
    - Match: token_valid and pkt_done pulse together.
    - Mismatch: pkt_done with pkt_error, err_code 2.
    - Another new_byte in TOK_END: go to DRAIN with err_code 3.
  - HS_END: rx_end gives pkt_done with pkt_error 0. Any new_byte goes to DRAIN with err_code 3.
  - DATA: each byte updates CRC16 (poly 0x8005, LSB first). Bytes enter a 2-deep holding buffer.
    - When a 3rd byte arrives, the oldest byte is emitted: data_valid one cycle after new_byte, and byte_count increments.
    - The CRC bytes therefore stay in the buffer and are never forwarded.
    - byte_count reaching MAX_PAYLOAD+1 goes to DRAIN with err_code 3.
    - On rx_end, fewer than 2 buffered bytes gives err_code 3. Otherwise the residual is checked against 16'h800D: match is good, mismatch is err_code 2.
  - DRAIN: ignore bytes. On rx_end, pulse pkt_done with pkt_error 1, then return to IDLE.
- rx_end in TOK1 or TOK2 gives a length error (code 3) immediately.
- rx_end in IDLE with no PID is ignored; no pkt_done.
- pkt_done is always followed by IDLE on the next cycle.
- new_byte and rx_end in the same cycle: the byte is processed first and the end is evaluated on the updated state/CRC.
- Payload bytes already forwarded before a CRC failure are not recalled. Downstream discards them on pkt_error.
- Latency:
  - pid_valid: 1 cycle after the PID new_byte.
  - data_valid: 1 cycle after the new_byte that pushes the byte out.
  - pkt_done: 1 cycle after rx_end.
- Asynchronous reset mid-packet aborts silently: no pkt_done, and the buffer is cleared.

Decomposition:
- Package usb_pkg:
  - PID constants, pid-class enum, err_code enum, decoder state enum.
  - CRC5_INIT, CRC5_RESIDUAL, CRC16_INIT, CRC16_RESIDUAL.
- Sub-module usb_crc_update: combinational 8-bit unrolled update, LSB first.
  - Inputs: byte, crc5_in, crc16_in.
  - Outputs: crc5_out, crc16_out.
  - Instanced once.

Test Plan:
- Bytes 0xD2 (ACK), then rx_end -> pid_valid with pid 2; pkt_done, pkt_error 0, byte_count 0.
- Bytes 0x69, 0x15, 0xBF (IN, addr 0x15, endp 0xE, CRC5 0x17), then rx_end -> token_valid, token_addr 0x15, token_endp 0xE, pkt_error 0. Flipping one bit of 0xBF -> pkt_error 1, err_code 2.
- Bytes 0x4B, 0x00, 0x00 (zero-length DATA1), then rx_end -> no data_valid, pkt_done, pkt_error 0, byte_count 0.
- DATA0 0xC3, payload 0x00 0x01 0x02 0x03, and CRC16 from the bench model, sent with new_byte every 4 cycles -> data_valid exactly 4 times carrying 00..03, CRC bytes not forwarded, byte_count 4, pkt_error 0. Last byte and rx_end in the same cycle -> same result.
- PID 0xC4, then rx_end -> no pid_valid, pkt_done, pkt_error 1, err_code 1. PID 0xF0 -> err_code 4.
- Token 0xE1 then rx_end after one byte -> err_code 3. Reset asserted mid-DATA -> all outputs 0, and no pkt_done after release.
